// File: rtl/w0rm_dvi_pkg.sv
// Shared types and raster timing presets for the DVI scanout path.
// Default timing is 1080p60; 720p60 and VGA 640x480 presets are kept alongside.
package w0rm_dvi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } scan_state_e;

  // Per-cycle raster flags, carried through the read-latency alignment pipe.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic first;
  } raster_t;

  localparam int unsigned DEF_H_ACTIVE = 1920;
  localparam int unsigned DEF_H_FP     = 88;
  localparam int unsigned DEF_H_SYNC   = 44;
  localparam int unsigned DEF_H_BP     = 148;
  localparam int unsigned DEF_V_ACTIVE = 1080;
  localparam int unsigned DEF_V_FP     = 4;
  localparam int unsigned DEF_V_SYNC   = 5;
  localparam int unsigned DEF_V_BP     = 36;

  localparam int unsigned P720_H_ACTIVE = 1280;
  localparam int unsigned P720_H_FP     = 110;
  localparam int unsigned P720_H_SYNC   = 40;
  localparam int unsigned P720_H_BP     = 220;
  localparam int unsigned P720_V_ACTIVE = 720;
  localparam int unsigned P720_V_FP     = 5;
  localparam int unsigned P720_V_SYNC   = 5;
  localparam int unsigned P720_V_BP     = 20;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

endpackage

// File: rtl/w0rm_dvi_timing_gen.sv
// Raster h/v counters with undelayed active/sync/first-pixel decode.
// Counters hold at (0,0) while run is low and free-run across frames while high.
module w0rm_dvi_timing_gen
  import w0rm_dvi_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    run,
  output raster_t raw,
  output logic    frame_end
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam int unsigned HS_BEGIN = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_BEGIN + H_SYNC;
  localparam int unsigned VS_BEGIN = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_BEGIN + V_SYNC;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          line_end;
  int unsigned   h;
  int unsigned   v;

  assign line_end  = (h_cnt == HW'(H_TOTAL - 1));
  assign frame_end = run && line_end && (v_cnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  always_comb begin
    h         = 32'(h_cnt);
    v         = 32'(v_cnt);
    raw       = '0;
    raw.act   = run && (h < H_ACTIVE) && (v < V_ACTIVE);
    raw.hs    = run && (h >= HS_BEGIN) && (h < HS_END);
    raw.vs    = run && (v >= VS_BEGIN) && (v < VS_END);
    raw.first = run && (h == 0) && (v == 0);
  end

endmodule

// File: rtl/w0rm_dvi_scanout_ctrl.sv
// DVI scanout sequencer: run/drain FSM, linear framebuffer read addressing,
// read-latency alignment of raster flags with returned pixel data, underrun flag.
module w0rm_dvi_scanout_ctrl
  import w0rm_dvi_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter bit          HS_POL      = 1'b1,
  parameter bit          VS_POL      = 1'b1,
  parameter int unsigned COLOR_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic                   sys_clk,
  input  logic                   cpu_reset,
  input  logic                   scan_enable_i,
  input  logic [ADDR_WIDTH-1:0]  fb_base_i,
  input  logic                   underrun_clr_i,
  output logic                   fb_rd_valid_o,
  output logic [ADDR_WIDTH-1:0]  fb_rd_addr_o,
  input  logic                   fb_rd_valid_i,
  input  logic [COLOR_WIDTH-1:0] fb_rd_data_i,
  output logic [COLOR_WIDTH-1:0] pix_color_o,
  output logic                   pix_valid_o,
  output logic                   h_sync_o,
  output logic                   v_sync_o,
  output logic                   frame_start_o,
  output logic                   busy_o,
  output logic                   underrun_o
);

  scan_state_e           state;
  scan_state_e           state_n;
  logic                  run;
  logic                  frame_end;
  raster_t               raw;
  raster_t               pipe [RD_LATENCY];
  raster_t               tail;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  underrun;

  assign run = (state != ST_IDLE);

  w0rm_dvi_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (sys_clk),
    .rst       (cpu_reset),
    .run       (run),
    .raw       (raw),
    .frame_end (frame_end)
  );

  always_ff @(posedge sys_clk or posedge cpu_reset) begin
    if (cpu_reset) state <= ST_IDLE;
    else           state <= state_n;
  end

  // A disabled scanout only stops on a frame boundary; re-enable mid-drain resumes seamlessly.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (scan_enable_i) state_n = ST_RUN;
      ST_RUN:   if (!scan_enable_i) state_n = frame_end ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (scan_enable_i)  state_n = ST_RUN;
        else if (frame_end) state_n = ST_IDLE;
      end
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      cur_addr <= '0;
    end else if (state == ST_IDLE) begin
      cur_addr <= scan_enable_i ? fb_base_i : '0;
    end else if (frame_end) begin
      cur_addr <= (state_n == ST_IDLE) ? '0 : fb_base_i;
    end else if (raw.act) begin
      cur_addr <= cur_addr + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= raw;
      for (int unsigned i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[RD_LATENCY-1];

  // Set beats clear when both land on the same cycle.
  always_ff @(posedge sys_clk or posedge cpu_reset) begin
    if (cpu_reset)                       underrun <= 1'b0;
    else if (tail.act && !fb_rd_valid_i) underrun <= 1'b1;
    else if (underrun_clr_i)             underrun <= 1'b0;
  end

  assign fb_rd_valid_o = raw.act;
  assign fb_rd_addr_o  = cur_addr;
  assign pix_valid_o   = tail.act;
  assign pix_color_o   = (tail.act && fb_rd_valid_i) ? fb_rd_data_i : '0;
  assign h_sync_o      = tail.hs ? HS_POL : ~HS_POL;
  assign v_sync_o      = tail.vs ? VS_POL : ~VS_POL;
  assign frame_start_o = tail.first;
  // Busy covers the draining frame as well, so it falls only once scanout has stopped.
  assign busy_o        = run;
  assign underrun_o    = underrun;

endmodule

// File: tb/tb_w0rm_dvi_scanout_ctrl.sv
// Scoreboard bench for w0rm_dvi_scanout_ctrl on an 8x6 raster with a
// latency-1 memory model that returns the read address as pixel data.
module tb_w0rm_dvi_scanout_ctrl;

  localparam int unsigned CW = 24;
  localparam int unsigned AW = 32;

  logic          clk;
  logic          rst;
  logic          en;
  logic [AW-1:0] base;
  logic          clr;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          mem_valid;
  logic [CW-1:0] mem_data;
  logic [CW-1:0] pix_color;
  logic          pix_valid, h_sync, v_sync, frame_start, busy, underrun;

  logic          b_rd_valid;
  logic [AW-1:0] b_rd_addr;
  logic [CW-1:0] b_pix_color;
  logic          b_pix_valid, b_h_sync, b_v_sync, b_frame_start, b_busy, b_underrun;

  logic          drop_en;
  logic [AW-1:0] drop_addr;

  typedef struct {
    logic [CW-1:0] color;
    logic          first;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   kk     = 0;

  w0rm_dvi_scanout_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .COLOR_WIDTH(CW), .ADDR_WIDTH(AW), .RD_LATENCY(1)
  ) dut (
    .sys_clk(clk), .cpu_reset(rst), .scan_enable_i(en), .fb_base_i(base),
    .underrun_clr_i(clr), .fb_rd_valid_o(rd_valid), .fb_rd_addr_o(rd_addr),
    .fb_rd_valid_i(mem_valid), .fb_rd_data_i(mem_data), .pix_color_o(pix_color),
    .pix_valid_o(pix_valid), .h_sync_o(h_sync), .v_sync_o(v_sync),
    .frame_start_o(frame_start), .busy_o(busy), .underrun_o(underrun)
  );

  w0rm_dvi_scanout_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .COLOR_WIDTH(CW), .ADDR_WIDTH(AW), .RD_LATENCY(1)
  ) dut_neg (
    .sys_clk(clk), .cpu_reset(rst), .scan_enable_i(en), .fb_base_i(base),
    .underrun_clr_i(clr), .fb_rd_valid_o(b_rd_valid), .fb_rd_addr_o(b_rd_addr),
    .fb_rd_valid_i(mem_valid), .fb_rd_data_i(mem_data), .pix_color_o(b_pix_color),
    .pix_valid_o(b_pix_valid), .h_sync_o(b_h_sync), .v_sync_o(b_v_sync),
    .frame_start_o(b_frame_start), .busy_o(b_busy), .underrun_o(b_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port-B memory: one-cycle latency, data equals address, optional dropped address.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_data  <= '0;
    end else begin
      mem_valid <= rd_valid && !(drop_en && rd_addr == drop_addr);
      mem_data  <= rd_addr[CW-1:0];
    end
  end

  // Monitor: every presented pixel is matched against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (pix_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pix_unexpected: got color %h first %b, required no pixel", pix_color, frame_start);
      end else begin
        e = exp_q.pop_front();
        if (pix_color !== e.color || frame_start !== e.first) begin
          errors++;
          $display("FAIL pix_data: got color %h first %b, required color %h first %b",
                   pix_color, frame_start, e.color, e.first);
        end
      end
    end else if (frame_start !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL frame_start_blank: got %b, required 0", frame_start);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s (k=%0d): got %h, required %h", name, kk, got, want);
    end
  endtask

  task automatic goto(input int t);
    while (kk < t) begin
      @(posedge clk);
      #1;
      kk++;
    end
  endtask

  task automatic start_frame_clock();
    @(posedge clk);
    #1;
    kk = 0;
  endtask

  task automatic push_frame(input logic [AW-1:0] fb, input int drop_idx);
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      e.color = (i == drop_idx) ? '0 : CW'(fb + AW'(i));
      e.first = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_valid"},  32'(rd_valid), 32'h0);
    chk({tag, "_rd_addr"},   rd_addr, 32'h0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'h0);
    chk({tag, "_pix_color"}, 32'(pix_color), 32'h0);
    chk({tag, "_h_sync"},    32'(h_sync), 32'h0);
    chk({tag, "_v_sync"},    32'(v_sync), 32'h0);
    chk({tag, "_h_sync_neg"}, 32'(b_h_sync), 32'h1);
    chk({tag, "_v_sync_neg"}, 32'(b_v_sync), 32'h1);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'h0);
    chk({tag, "_busy"},      32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required orderly finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int c;
    rst = 1'b1; en = 1'b0; base = '0; clr = 1'b0; drop_en = 1'b0; drop_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset_underrun", 32'(underrun), 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Frames 1 and 2 from 0x100, sync/read-strobe shape checked across frame 1.
    base = 32'h100;
    push_frame(32'h100, -1);
    push_frame(32'h100, -1);
    en = 1'b1;
    start_frame_clock();
    chk("first_busy", 32'(busy), 32'h1);
    chk("first_rd_valid", 32'(rd_valid), 32'h1);
    chk("first_rd_addr", rd_addr, 32'h100);
    for (int k = 1; k <= 48; k++) begin
      goto(k);
      c = k - 1;
      chk("h_sync", 32'(h_sync), ((c % 8 == 5) || (c % 8 == 6)) ? 32'h1 : 32'h0);
      chk("v_sync", 32'(v_sync), (c / 8 == 4) ? 32'h1 : 32'h0);
      chk("h_sync_neg", 32'(b_h_sync), ((c % 8 == 5) || (c % 8 == 6)) ? 32'h0 : 32'h1);
      chk("v_sync_neg", 32'(b_v_sync), (c / 8 == 4) ? 32'h0 : 32'h1);
      chk("rd_valid", 32'(rd_valid), ((k % 8 < 4) && ((k % 48) / 8 < 3)) ? 32'h1 : 32'h0);
    end

    // Base change mid-frame 2 applies from frame 3; frame 3 loses pixel 5.
    goto(60);
    base = 32'h200;
    push_frame(32'h200, 5);
    drop_addr = 32'h205;
    drop_en = 1'b1;
    goto(106);
    chk("drop_pix_valid", 32'(pix_valid), 32'h1);
    chk("underrun_before", 32'(underrun), 32'h0);
    goto(107);
    chk("underrun_set", 32'(underrun), 32'h1);
    goto(120);
    chk("underrun_sticky", 32'(underrun), 32'h1);
    clr = 1'b1;
    goto(121);
    clr = 1'b0;
    chk("underrun_cleared", 32'(underrun), 32'h0);

    // Frame 4: clear asserted on the same cycle as a new underrun.
    goto(140);
    drop_addr = 32'h202;
    push_frame(32'h200, 2);
    goto(147);
    clr = 1'b1;
    goto(148);
    clr = 1'b0;
    chk("underrun_set_wins", 32'(underrun), 32'h1);
    goto(150);
    chk("underrun_hold", 32'(underrun), 32'h1);

    // Frame 5: disable at frame cycle 10, frame runs out then stops.
    goto(180);
    drop_en = 1'b0;
    push_frame(32'h200, -1);
    goto(202);
    en = 1'b0;
    goto(208);
    chk("drain_rd_valid", 32'(rd_valid), 32'h1);
    chk("drain_rd_addr", rd_addr, 32'h208);
    goto(240);
    chk("stop_busy", 32'(busy), 32'h0);
    chk("stop_rd_valid", 32'(rd_valid), 32'h0);
    goto(241);
    chk_idle_outputs("idle");
    chk("idle_underrun_kept", 32'(underrun), 32'h1);
    goto(250);
    chk("queue_drained_a", 32'(exp_q.size()), 32'h0);

    // Disable then re-enable within a frame: next frame follows with no gap.
    base = 32'h300;
    push_frame(32'h300, -1);
    push_frame(32'h300, -1);
    en = 1'b1;
    start_frame_clock();
    goto(10);
    en = 1'b0;
    goto(20);
    en = 1'b1;
    goto(48);
    chk("nogap_rd_valid", 32'(rd_valid), 32'h1);
    chk("nogap_rd_addr", rd_addr, 32'h300);
    chk("nogap_busy", 32'(busy), 32'h1);
    goto(70);
    chk("pre_reset_h_sync", 32'(h_sync), 32'h1);

    // Asynchronous reset mid-line, observed before the next clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk_idle_outputs("async_reset");
    chk("async_reset_underrun", 32'(underrun), 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    push_frame(32'h300, -1);
    rst = 1'b0;
    start_frame_clock();
    chk("restart_rd_valid", 32'(rd_valid), 32'h1);
    chk("restart_rd_addr", rd_addr, 32'h300);
    goto(30);
    en = 1'b0;
    goto(52);
    chk("restart_stopped", 32'(busy), 32'h0);
    chk("queue_drained_b", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
